sram_req_arbiter_ctrl: RTL and testbench

//  Shares one single-port 1rw SRAM macro (32b x 128, csb0/web0 active-low, 1-cycle read)

---
 rtl/sram_req_arbiter_ctrl.sv | 139 +++++++++++++
 tb/tb_sram_req_arbiter_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter_ctrl.sv
// Round-robin front end that shares one 1rw SRAM macro between two val/rdy requesters.
// SRAM read latency is hidden by a one-deep in-flight stage feeding a shared 2-entry response queue.
module sram_req_arbiter_ctrl #(
   parameter  int p_data_nbits  = 32,
   parameter  int p_num_entries = 128,
   localparam int p_addr_nbits  = $clog2(p_num_entries),
   localparam int p_mask_nbits  = p_data_nbits / 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req0_val,
   output logic                    req0_rdy,
   input  logic                    req0_type,
   input  logic [p_addr_nbits-1:0] req0_addr,
   input  logic [p_mask_nbits-1:0] req0_wmask,
   input  logic [p_data_nbits-1:0] req0_data,
   input  logic                    req1_val,
   output logic                    req1_rdy,
   input  logic                    req1_type,
   input  logic [p_addr_nbits-1:0] req1_addr,
   input  logic [p_mask_nbits-1:0] req1_wmask,
   input  logic [p_data_nbits-1:0] req1_data,
   output logic                    resp0_val,
   input  logic                    resp0_rdy,
   output logic                    resp0_type,
   output logic [p_data_nbits-1:0] resp0_data,
   output logic                    resp1_val,
   input  logic                    resp1_rdy,
   output logic                    resp1_type,
   output logic [p_data_nbits-1:0] resp1_data,
   output logic                    sram_csb0,
   output logic                    sram_web0,
   output logic [p_mask_nbits-1:0] sram_wmask0,
   output logic [p_addr_nbits-1:0] sram_addr0,
   output logic [p_data_nbits-1:0] sram_din0,
   input  logic [p_data_nbits-1:0] sram_dout0
);

   logic                    r_ready;
   logic                    r_inflight;
   logic                    r_inf_id;
   logic                    r_inf_type;
   logic                    r_rr;
   logic                    r_head;
   logic [1:0]              r_count;
   logic                    r_q_id   [2];
   logic                    r_q_type [2];
   logic [p_data_nbits-1:0] r_q_data [2];

   logic       w_nonempty;
   logic       w_head_id;
   logic       w_resp_fire;
   logic [2:0] w_outstanding;
   logic       w_can_issue;
   logic       w_grant;
   logic       w_fire;
   logic       w_push;
   logic       w_tail;

   assign w_nonempty  = (r_count != 2'd0);
   assign w_head_id   = r_q_id[r_head];
   assign w_resp_fire = w_nonempty & (w_head_id ? resp1_rdy : resp0_rdy);

   // Outstanding work after this cycle's pop; a new issue must leave room in the queue.
   assign w_outstanding = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_resp_fire};
   assign w_can_issue   = r_ready & (w_outstanding < 3'd2);

   assign w_grant  = (req0_val & req1_val) ? r_rr : req1_val;
   assign req0_rdy = w_can_issue & ~w_grant;
   assign req1_rdy = w_can_issue & w_grant;
   assign w_fire   = w_grant ? (req1_val & req1_rdy) : (req0_val & req0_rdy);

   always_comb begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = '0;
      sram_addr0  = '0;
      sram_din0   = '0;
      if (w_fire) begin
         sram_csb0 = 1'b0;
         if (w_grant) begin
            sram_web0   = ~req1_type;
            sram_wmask0 = req1_wmask;
            sram_addr0  = req1_addr;
            sram_din0   = req1_data;
         end else begin
            sram_web0   = ~req0_type;
            sram_wmask0 = req0_wmask;
            sram_addr0  = req0_addr;
            sram_din0   = req0_data;
         end
      end
   end

   // A push only happens with at most one entry queued, so head^count[0] is always a free slot.
   assign w_push = r_inflight;
   assign w_tail = r_head ^ r_count[0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ready    <= 1'b0;
         r_inflight <= 1'b0;
         r_inf_id   <= 1'b0;
         r_inf_type <= 1'b0;
         r_rr       <= 1'b0;
         r_head     <= 1'b0;
         r_count    <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_q_id[i]   <= 1'b0;
            r_q_type[i] <= 1'b0;
            r_q_data[i] <= '0;
         end
      end else begin
         r_ready    <= 1'b1;
         r_inflight <= w_fire;
         if (w_fire) begin
            r_inf_id   <= w_grant;
            r_inf_type <= w_grant ? req1_type : req0_type;
            r_rr       <= ~w_grant;
         end
         if (w_push) begin
            r_q_id[w_tail]   <= r_inf_id;
            r_q_type[w_tail] <= r_inf_type;
            r_q_data[w_tail] <= r_inf_type ? '0 : sram_dout0;
         end
         if (w_resp_fire)
            r_head <= ~r_head;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_resp_fire};
      end
   end

   assign resp0_val  = w_nonempty & ~w_head_id;
   assign resp1_val  = w_nonempty & w_head_id;
   assign resp0_type = r_q_type[r_head];
   assign resp1_type = r_q_type[r_head];
   assign resp0_data = r_q_data[r_head];
   assign resp1_data = r_q_data[r_head];

endmodule

// File: tb/tb_sram_req_arbiter_ctrl.sv
// Directed and randomised checks of sram_req_arbiter_ctrl against a behavioural SRAM
// and a reference memory with per-port expected-response queues.
module tb_sram_req_arbiter_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req0_val, req0_rdy, req0_type;
   logic [6:0]  req0_addr;
   logic [3:0]  req0_wmask;
   logic [31:0] req0_data;
   logic        req1_val, req1_rdy, req1_type;
   logic [6:0]  req1_addr;
   logic [3:0]  req1_wmask;
   logic [31:0] req1_data;
   logic        resp0_val, resp0_rdy, resp0_type;
   logic [31:0] resp0_data;
   logic        resp1_val, resp1_rdy, resp1_type;
   logic [31:0] resp1_data;
   logic        sram_csb0, sram_web0;
   logic [3:0]  sram_wmask0;
   logic [6:0]  sram_addr0;
   logic [31:0] sram_din0;
   logic [31:0] sram_dout0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem     [128];
   logic [31:0] ref_mem [8];
   logic [32:0] q0 [$];
   logic [32:0] q1 [$];

   always #5 clk = ~clk;

   sram_req_arbiter_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_type(req0_type),
      .req0_addr(req0_addr), .req0_wmask(req0_wmask), .req0_data(req0_data),
      .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_type(req1_type),
      .req1_addr(req1_addr), .req1_wmask(req1_wmask), .req1_data(req1_data),
      .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_type(resp0_type), .resp0_data(resp0_data),
      .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_type(resp1_type), .resp1_data(resp1_data),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
      .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
   );

   // Behavioural 1rw macro: masked byte writes, registered read data.
   always @(posedge clk) begin
      if (!sram_csb0) begin
         if (!sram_web0) begin
            for (int b = 0; b < 4; b++)
               if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
         end else begin
            sram_dout0 <= mem[sram_addr0];
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input int port, input logic typ, input logic [6:0] addr,
                         input logic [31:0] data, input logic [3:0] mask,
                         input logic [31:0] exp_data, input string tag);
      logic got;
      if (port == 0) begin
         req0_val = 1'b1; req0_type = typ; req0_addr = addr; req0_data = data; req0_wmask = mask;
      end else begin
         req1_val = 1'b1; req1_type = typ; req1_addr = addr; req1_data = data; req1_wmask = mask;
      end
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         got = (port == 0) ? req0_rdy : req1_rdy;
         if (!got) tick();
      end
      check_val({tag, "_issue"}, 32'(got), 1);
      tick();
      req0_val = 1'b0;
      req1_val = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         got = (port == 0) ? resp0_val : resp1_val;
         if (!got) tick();
      end
      check_val({tag, "_rval"}, 32'(got), 1);
      check_val({tag, "_type"}, 32'((port == 0) ? resp0_type : resp1_type), 32'(typ));
      check_val({tag, "_data"}, (port == 0) ? resp0_data : resp1_data, exp_data);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic f0, f1;
      logic [32:0] exp;
      reset_n = 1'b0;
      req0_val = 0; req0_type = 0; req0_addr = 0; req0_wmask = 0; req0_data = 0;
      req1_val = 0; req1_type = 0; req1_addr = 0; req1_wmask = 0; req1_data = 0;
      resp0_rdy = 1; resp1_rdy = 1;

      // Reset state
      tick(); tick();
      @(negedge clk);
      check_val("rst_req0_rdy", 32'(req0_rdy), 0);
      check_val("rst_req1_rdy", 32'(req1_rdy), 0);
      check_val("rst_resp0_val", 32'(resp0_val), 0);
      check_val("rst_resp1_val", 32'(resp1_val), 0);
      check_val("rst_csb0", 32'(sram_csb0), 1);
      check_val("rst_web0", 32'(sram_web0), 1);
      check_val("rst_addr0", 32'(sram_addr0), 0);
      tick();
      reset_n = 1'b1;
      tick(); tick();

      // Write then read addr 5, cycle-exact
      req0_val = 1; req0_type = 1; req0_addr = 7'd5; req0_data = 32'hDEADBEEF; req0_wmask = 4'hF;
      @(negedge clk);
      check_val("t1_wr_rdy", 32'(req0_rdy), 1);
      check_val("t1_wr_csb", 32'(sram_csb0), 0);
      check_val("t1_wr_web", 32'(sram_web0), 0);
      check_val("t1_wr_addr", 32'(sram_addr0), 5);
      check_val("t1_wr_din", sram_din0, 32'hDEADBEEF);
      check_val("t1_wr_mask", 32'(sram_wmask0), 32'hF);
      tick();
      req0_type = 0; req0_data = 0; req0_wmask = 0;
      @(negedge clk);
      check_val("t1_rd_rdy", 32'(req0_rdy), 1);
      check_val("t1_rd_csb", 32'(sram_csb0), 0);
      check_val("t1_rd_web", 32'(sram_web0), 1);
      tick();
      req0_val = 0;
      @(negedge clk);
      check_val("t1_ack_val", 32'(resp0_val), 1);
      check_val("t1_ack_type", 32'(resp0_type), 1);
      check_val("t1_ack_data", resp0_data, 0);
      check_val("t1_ack_r1val", 32'(resp1_val), 0);
      tick();
      @(negedge clk);
      check_val("t1_rd_val", 32'(resp0_val), 1);
      check_val("t1_rd_type", 32'(resp0_type), 0);
      check_val("t1_rd_data", resp0_data, 32'hDEADBEEF);
      tick();
      @(negedge clk);
      check_val("t1_empty", 32'(resp0_val), 0);
      tick();

      // Alternating grants from a fresh reset, one response per cycle
      reset_n = 1'b0; tick(); reset_n = 1'b1; tick(); tick();
      req0_val = 1; req0_type = 0; req0_addr = 7'd5;
      req1_val = 1; req1_type = 0; req1_addr = 7'd5; req1_data = 0; req1_wmask = 0;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) begin req0_val = 0; req1_val = 0; end
         @(negedge clk);
         if (i < 4) begin
            check_val($sformatf("t2_rdy0_%0d", i), 32'(req0_rdy), 32'((i % 2) == 0));
            check_val($sformatf("t2_rdy1_%0d", i), 32'(req1_rdy), 32'((i % 2) == 1));
         end
         if (i >= 2) begin
            check_val($sformatf("t2_rv0_%0d", i), 32'(resp0_val), 32'((i % 2) == 0));
            check_val($sformatf("t2_rv1_%0d", i), 32'(resp1_val), 32'((i % 2) == 1));
            check_val($sformatf("t2_rd_%0d", i), (i % 2 == 0) ? resp0_data : resp1_data, 32'hDEADBEEF);
         end
         tick();
      end

      // Back-pressure: stalled head held, issue stops at two outstanding
      resp0_rdy = 0;
      req0_val = 1; req0_type = 0; req0_addr = 7'd5;
      @(negedge clk); check_val("t3_rdy_c0", 32'(req0_rdy), 1);
      tick(); req0_addr = 7'd6;
      @(negedge clk); check_val("t3_rdy_c1", 32'(req0_rdy), 1);
      tick(); req0_addr = 7'd7;
      @(negedge clk);
      check_val("t3_rdy_c2", 32'(req0_rdy), 0);
      check_val("t3_val_c2", 32'(resp0_val), 1);
      check_val("t3_data_c2", resp0_data, 32'hDEADBEEF);
      tick();
      @(negedge clk);
      check_val("t3_rdy_c3", 32'(req0_rdy), 0);
      check_val("t3_csb_c3", 32'(sram_csb0), 1);
      check_val("t3_val_c3", 32'(resp0_val), 1);
      check_val("t3_type_c3", 32'(resp0_type), 0);
      check_val("t3_data_c3", resp0_data, 32'hDEADBEEF);
      tick(); resp0_rdy = 1;
      @(negedge clk);
      check_val("t3_rdy_c4", 32'(req0_rdy), 1);
      check_val("t3_addr_c4", 32'(sram_addr0), 7);
      tick(); req0_val = 0;
      @(negedge clk); check_val("t3_val_c5", 32'(resp0_val), 1);
      tick();
      @(negedge clk); check_val("t3_val_c6", 32'(resp0_val), 1);
      tick();
      @(negedge clk); check_val("t3_val_c7", 32'(resp0_val), 0);
      tick();

      // Partial and zero-mask writes
      do_req(0, 1'b1, 7'd9, 32'h11223344, 4'hF,    32'h0, "t4_wfull");
      do_req(0, 1'b1, 7'd9, 32'h0000AB00, 4'b0010, 32'h0, "t4_wpart");
      do_req(1, 1'b0, 7'd9, 32'h0,        4'h0,    32'h1122AB44, "t4_rd1");
      do_req(1, 1'b1, 7'd9, 32'hFFFFFFFF, 4'h0,    32'h0, "t4_wzero");
      do_req(0, 1'b0, 7'd9, 32'h0,        4'h0,    32'h1122AB44, "t4_rd2");

      // Reset while a read is in flight and the queue holds an entry
      resp0_rdy = 0;
      req0_val = 1; req0_type = 0; req0_addr = 7'd5;
      tick(); tick();
      reset_n = 1'b0;
      @(negedge clk);
      check_val("t5_rv0", 32'(resp0_val), 0);
      check_val("t5_rv1", 32'(resp1_val), 0);
      check_val("t5_csb", 32'(sram_csb0), 1);
      check_val("t5_rdy0", 32'(req0_rdy), 0);
      tick();
      reset_n = 1'b1; req0_val = 0; resp0_rdy = 1;
      tick(); tick();
      @(negedge clk);
      check_val("t5_dropped", 32'(resp0_val), 0);
      tick();
      req0_val = 1; req1_val = 1; req1_type = 0; req1_addr = 7'd5;
      @(negedge clk);
      check_val("t5_rr_rdy0", 32'(req0_rdy), 1);
      check_val("t5_rr_rdy1", 32'(req1_rdy), 0);
      tick();
      req0_val = 0; req1_val = 0;
      tick(); tick(); tick();

      // Random two-port traffic against a reference memory
      for (int a = 0; a < 8; a++) begin
         ref_mem[a] = 32'hA5000000 | 32'(a);
         do_req(0, 1'b1, 7'(a), ref_mem[a], 4'hF, 32'h0, "t6_init");
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!req0_val && $urandom_range(1, 0) == 1) begin
            req0_val = 1; req0_type = 1'($urandom_range(1, 0)); req0_addr = 7'($urandom_range(7, 0));
            req0_data = $urandom; req0_wmask = 4'($urandom_range(15, 0));
         end
         if (!req1_val && $urandom_range(1, 0) == 1) begin
            req1_val = 1; req1_type = 1'($urandom_range(1, 0)); req1_addr = 7'($urandom_range(7, 0));
            req1_data = $urandom; req1_wmask = 4'($urandom_range(15, 0));
         end
         resp0_rdy = ($urandom_range(3, 0) != 0);
         resp1_rdy = ($urandom_range(3, 0) != 0);
         @(negedge clk);
         if (resp0_val && resp1_val) check_val("t6_onehot", 32'(resp0_val & resp1_val), 0);
         if (resp0_val && resp0_rdy) begin
            check_val("t6_q0_nonempty", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
               exp = q0.pop_front();
               check_val("t6_r0_type", 32'(resp0_type), 32'(exp[32]));
               check_val("t6_r0_data", resp0_data, exp[31:0]);
            end
         end
         if (resp1_val && resp1_rdy) begin
            check_val("t6_q1_nonempty", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
               exp = q1.pop_front();
               check_val("t6_r1_type", 32'(resp1_type), 32'(exp[32]));
               check_val("t6_r1_data", resp1_data, exp[31:0]);
            end
         end
         f0 = req0_val & req0_rdy;
         f1 = req1_val & req1_rdy;
         if (f0) begin
            if (req0_type) begin
               for (int b = 0; b < 4; b++)
                  if (req0_wmask[b]) ref_mem[req0_addr[2:0]][b*8 +: 8] = req0_data[b*8 +: 8];
               q0.push_back({1'b1, 32'h0});
            end else begin
               q0.push_back({1'b0, ref_mem[req0_addr[2:0]]});
            end
         end
         if (f1) begin
            if (req1_type) begin
               for (int b = 0; b < 4; b++)
                  if (req1_wmask[b]) ref_mem[req1_addr[2:0]][b*8 +: 8] = req1_data[b*8 +: 8];
               q1.push_back({1'b1, 32'h0});
            end else begin
               q1.push_back({1'b0, ref_mem[req1_addr[2:0]]});
            end
         end
         tick();
         if (f0) req0_val = 0;
         if (f1) req1_val = 0;
      end
      req0_val = 0; req1_val = 0;
      for (int k = 0; k < 8; k++) begin
         resp0_rdy = 1; resp1_rdy = 1;
         @(negedge clk);
         if (resp0_val) begin
            check_val("t6_q0_nonempty", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
               exp = q0.pop_front();
               check_val("t6_r0_type", 32'(resp0_type), 32'(exp[32]));
               check_val("t6_r0_data", resp0_data, exp[31:0]);
            end
         end
         if (resp1_val) begin
            check_val("t6_q1_nonempty", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
               exp = q1.pop_front();
               check_val("t6_r1_type", 32'(resp1_type), 32'(exp[32]));
               check_val("t6_r1_data", resp1_data, exp[31:0]);
            end
         end
         tick();
      end
      check_val("t6_drain0", q0.size(), 0);
      check_val("t6_drain1", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
